// File: rtl/dmem_lsu.sv
// Byte-addressed data memory behind a RISC-V load/store front end; DMEM_BOUNDS_CHECK_EN adds out-of-range faulting.
// Response arrives WAIT_STATES cycles after the accept cycle; one request at a time, req_valid outside IDLE is ignored.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        enter_resp;
  logic        accept;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};

  // With zero wait states the access happens on the accept edge itself, so decode from the live inputs.
  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [1:0]  lane;
  logic [AW-1:0] widx;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] merged;
  logic        illegal;
  logic        misalign;
  logic        oob;
  logic        acc_fault;

  assign accept    = req_valid && req_ready;
  assign acc_we    = (state == S_IDLE) ? req_we     : we_q;
  assign acc_f3    = (state == S_IDLE) ? req_funct3 : f3_q;
  assign acc_addr  = (state == S_IDLE) ? alu_result : addr_q;
  assign acc_wdata = (state == S_IDLE) ? wdata      : wdata_q;

  assign lane    = acc_addr[1:0];
  assign widx    = acc_addr[AW+1:2];
  assign rd_word = mem[widx];

  assign illegal  = acc_we ? (acc_f3 > 3'd2)
                           : (acc_f3 == 3'b011 || acc_f3 == 3'b110 || acc_f3 == 3'b111);
  assign misalign = (acc_f3[1:0] == 2'b01 && acc_addr[0]) ||
                    (acc_f3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00);

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = (acc_addr >= 32'(DEPTH_WORDS * 4));
`else
  // Upper address bits intentionally ignored: addresses wrap.
  logic unused_hi;
  assign unused_hi = ^acc_addr[31:AW+2];
  assign oob       = 1'b0;
`endif

  assign acc_fault = illegal | misalign | oob;

  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      2'd3:    byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_f3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      3'b010:  load_val = rd_word;
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wword = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wword = acc_wdata;
      end
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wword[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= alu_result;
        wdata_q <= wdata;
        cnt     <= WS_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (acc_fault || acc_we) ? 32'h0 : load_val;
        fault_q <= acc_fault;
      end else if (state == S_RESP) begin
        rdata_q <= 32'h0;
        fault_q <= 1'b0;
      end
    end
  end

  // Array is not reset; enter_resp is already low whenever rst is high.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_fault) begin
      mem[widx] <= merged;
    end
  end

  assign req_ready  = (state == S_IDLE) && !rst;
  assign resp_valid = (state == S_RESP);
  assign rdata      = rdata_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (1024 words / 0 waits, 16 words / 3 waits) against a byte-array reference model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic [31:0] rdata     [2];
  logic        fault     [2];

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_f3[0]), .alu_result(req_addr[0]), .wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .rdata(rdata[0]), .fault(fault[0])
  );

  dmem_lsu #(.DEPTH_WORDS(16), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_f3[1]), .alu_result(req_addr[1]), .wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .rdata(rdata[1]), .fault(fault[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mm [2][4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int span_bytes(input int d);
    return (d == 0) ? 4096 : 64;
  endfunction

  function automatic int waits(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: memory is a flat byte array; accesses are size-aligned byte runs.
  function automatic void model(input int d, input logic w, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] v,
                                output logic [31:0] r, output logic flt);
    int n  = span_bytes(d);
    int sz = 1 << f[1:0];
    int base;
    bit bad;
    logic [31:0] val = 32'h0;
    bad = (f[1:0] == 2'd3) || (w && f[2]) || (!w && f == 3'b110) || ((a % sz) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (a >= n) bad = 1'b1;
`endif
    base = int'(a % n);
    r    = 32'h0;
    flt  = bad;
    if (bad) return;
    if (w) begin
      for (int i = 0; i < sz; i++) mm[d][base+i] = v[8*i +: 8];
    end else begin
      for (int i = 0; i < sz; i++) val = val | (32'(mm[d][base+i]) << (8*i));
      if (!f[2] && sz < 4 && val[8*sz-1]) val = val | ~((32'd1 << (8*sz)) - 32'd1);
      r = val;
    end
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 after the edge following the response.
  task automatic txn(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] v, input bit hold,
                     output logic [31:0] r_o, output logic f_o);
    logic [31:0] er;
    logic        ef;
    int          lat;
    chk("ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = w; req_f3[d] = f; req_addr[d] = a; req_wdata[d] = v;
    @(posedge clk); #1;
    model(d, w, f, a, v, er, ef);
    if (!hold) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'($urandom_range(0, 1));
      req_f3[d]    = 3'($urandom_range(0, 7));
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
    end
    lat = 0;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      chk("ready_busy", 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    req_valid[d] = 1'b0;
    chk("latency", 32'(lat), 32'(waits(d)));
    chk("ready_in_resp", 32'(req_ready[d]), 32'd0);
    chk("rdata", rdata[d], er);
    chk("fault", 32'(fault[d]), 32'(ef));
    r_o = rdata[d];
    f_o = fault[d];
    @(posedge clk); #1;
    chk("resp_one_cycle", 32'(resp_valid[d]), 32'd0);
    chk("rdata_cleared", rdata[d], 32'h0);
    chk("fault_cleared", 32'(fault[d]), 32'd0);
    if (hold) begin
      for (int i = 0; i < 6; i++) begin
        chk("no_second_accept", 32'(resp_valid[d]), 32'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        fl;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4096; i++) mm[d][i] = 8'h0;
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_f3[d] = 3'd0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(req_ready[d]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_fault", 32'(fault[d]), 32'd0);
      rst[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) chk("ready_after_rst", 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;

    // Basic word round trip, zero wait states
    txn(0, 1'b1, 3'b010, 32'h28, 32'hA5A5A5A5, 1'b0, r, fl);
    txn(0, 1'b0, 3'b010, 32'h28, 32'h0, 1'b0, r, fl);
    chk("lw_0x28", r, 32'hA5A5A5A5);
    chk("lw_0x28_fault", 32'(fl), 32'd0);

    // Byte lanes
    txn(0, 1'b1, 3'b010, 32'h40, 32'h00000000, 1'b0, r, fl);
    txn(0, 1'b1, 3'b000, 32'h41, 32'hFFFFFF80, 1'b0, r, fl);
    txn(0, 1'b1, 3'b001, 32'h42, 32'h7777BEEF, 1'b0, r, fl);
    txn(0, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, r, fl);
    chk("lw_lanes", r, 32'hBEEF8000);
    txn(0, 1'b0, 3'b000, 32'h41, 32'h0, 1'b0, r, fl);
    chk("lb_0x41", r, 32'hFFFFFF80);
    txn(0, 1'b0, 3'b100, 32'h41, 32'h0, 1'b0, r, fl);
    chk("lbu_0x41", r, 32'h00000080);
    txn(0, 1'b0, 3'b001, 32'h42, 32'h0, 1'b0, r, fl);
    chk("lh_0x42", r, 32'hFFFFBEEF);
    txn(0, 1'b0, 3'b101, 32'h42, 32'h0, 1'b0, r, fl);
    chk("lhu_0x42", r, 32'h0000BEEF);

    // Faults
    txn(0, 1'b0, 3'b010, 32'h2A, 32'h0, 1'b0, r, fl);
    chk("lw_misaligned_fault", 32'(fl), 32'd1);
    chk("lw_misaligned_rdata", r, 32'h0);
    txn(0, 1'b1, 3'b001, 32'h43, 32'h00001234, 1'b0, r, fl);
    chk("sh_misaligned_fault", 32'(fl), 32'd1);
    txn(0, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, r, fl);
    chk("lw_after_bad_sh", r, 32'hBEEF8000);
    txn(0, 1'b0, 3'b011, 32'h40, 32'h0, 1'b0, r, fl);
    chk("ld_funct3_011_fault", 32'(fl), 32'd1);
    txn(0, 1'b1, 3'b100, 32'h40, 32'h12345678, 1'b0, r, fl);
    chk("st_funct3_100_fault", 32'(fl), 32'd1);

    // Wait states with req_valid held through the busy window
    txn(1, 1'b1, 3'b010, 32'h04, 32'h01020304, 1'b1, r, fl);
    txn(1, 1'b0, 3'b010, 32'h04, 32'h0, 1'b1, r, fl);
    chk("ws3_lw", r, 32'h01020304);

    // Reset during WAIT abandons the store
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_f3[1] = 3'b010;
    req_addr[1] = 32'h10; req_wdata[1] = 32'h11111111;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    #1;
    chk("ready_during_rst", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("no_resp_after_rst", 32'(resp_valid[1]), 32'd0);
      @(posedge clk); #1;
    end
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, r, fl);
    chk("lw_after_abandon", r, 32'h0);

    // Bounds / wrap on the 16-word instance
`ifdef DMEM_BOUNDS_CHECK_EN
    txn(1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, r, fl);
    chk("oob_lw_fault", 32'(fl), 32'd1);
`else
    txn(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b0, r, fl);
    txn(1, 1'b0, 3'b010, 32'h00, 32'h0, 1'b0, r, fl);
    chk("wrap_lw", r, 32'hCAFEF00D);
    chk("wrap_lw_fault", 32'(fl), 32'd0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      txn(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0, r, fl);
    end
    for (int k = 0; k < 100; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(64, 255)) : 32'($urandom_range(0, 63));
      txn(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          1'($urandom_range(0, 1)), r, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
